// File: rtl/qtable_best_hop_select.sv
// Scans the neighbour Q-table banks and returns the eligible entry with the highest Q-value.
// Ties keep the lowest index. An excluded or zero ID is never chosen.
//
// state | meaning
// IDLE  | waiting for en; outputs hold the last result
// ADDR  | memory banks capture rd_index
// CMP   | compare bank data for entry rd_index against the current best
// FIN   | pulse done, drop busy
module qtable_best_hop_select #(
    parameter int WORD_WIDTH    = 16,
    parameter int MAX_NEIGHBORS = 16,
    parameter int IDX_WIDTH     = 4
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic [WORD_WIDTH-1:0] neighborCount,
    input  logic [WORD_WIDTH-1:0] excludeID,
    output logic [IDX_WIDTH-1:0]  rd_index,
    input  logic [WORD_WIDTH-1:0] mSourceID,
    input  logic [WORD_WIDTH-1:0] mSourceHops,
    input  logic [WORD_WIDTH-1:0] mQValue,
    output logic [WORD_WIDTH-1:0] bestID,
    output logic [WORD_WIDTH-1:0] bestHops,
    output logic [WORD_WIDTH-1:0] bestQ,
    output logic                  found,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        CMP  = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [WORD_WIDTH-1:0] MAX_CNT = WORD_WIDTH'(MAX_NEIGHBORS);
    localparam logic [WORD_WIDTH-1:0] ONE_W   = WORD_WIDTH'(1);
    localparam logic [IDX_WIDTH-1:0]  ONE_I   = IDX_WIDTH'(1);

    state_t                state;
    logic [WORD_WIDTH-1:0] cnt;
    logic [WORD_WIDTH-1:0] excl;
    logic                  eligible;
    logic                  take;
    logic                  last;

    always_comb begin
        eligible = (mSourceID != '0) && ((excl == '0) || (mSourceID != excl));
        take     = eligible && (!found || (mQValue > bestQ));
        last     = (WORD_WIDTH'(rd_index) == (cnt - ONE_W));
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state    <= IDLE;
            cnt      <= '0;
            excl     <= '0;
            rd_index <= '0;
            bestID   <= '0;
            bestHops <= '0;
            bestQ    <= '0;
            found    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (en) begin
                        cnt      <= (neighborCount > MAX_CNT) ? MAX_CNT : neighborCount;
                        excl     <= excludeID;
                        rd_index <= '0;
                        bestID   <= '0;
                        bestHops <= '0;
                        bestQ    <= '0;
                        found    <= 1'b0;
                        busy     <= 1'b1;
                        state    <= (neighborCount == '0) ? FIN : ADDR;
                    end
                end
                ADDR: begin
                    state <= CMP;
                end
                CMP: begin
                    if (take) begin
                        bestID   <= mSourceID;
                        bestHops <= mSourceHops;
                        bestQ    <= mQValue;
                        found    <= 1'b1;
                    end
                    if (last) begin
                        state <= FIN;
                    end else begin
                        rd_index <= rd_index + ONE_I;
                        state    <= ADDR;
                    end
                end
                FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_qtable_best_hop_select.sv
// Scoreboard bench for qtable_best_hop_select: directed scans push expected results,
// a negedge monitor pops and compares on every done pulse.
module tb_qtable_best_hop_select;

    logic        clk = 1'b0;
    logic        nrst;
    logic        en;
    logic [15:0] neighborCount;
    logic [15:0] excludeID;
    logic [3:0]  rd_index;
    logic [15:0] mSourceID;
    logic [15:0] mSourceHops;
    logic [15:0] mQValue;
    logic [15:0] bestID;
    logic [15:0] bestHops;
    logic [15:0] bestQ;
    logic        found;
    logic        busy;
    logic        done;

    qtable_best_hop_select #(
        .WORD_WIDTH(16), .MAX_NEIGHBORS(16), .IDX_WIDTH(4)
    ) dut (
        .clk(clk), .nrst(nrst), .en(en),
        .neighborCount(neighborCount), .excludeID(excludeID),
        .rd_index(rd_index),
        .mSourceID(mSourceID), .mSourceHops(mSourceHops), .mQValue(mQValue),
        .bestID(bestID), .bestHops(bestHops), .bestQ(bestQ),
        .found(found), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [15:0] tab_id   [16];
    logic [15:0] tab_hops [16];
    logic [15:0] tab_q    [16];

    // Banks register the address, so data lags rd_index by one cycle.
    always @(posedge clk) begin
        mSourceID   <= tab_id[rd_index];
        mSourceHops <= tab_hops[rd_index];
        mQValue     <= tab_q[rd_index];
    end

    typedef struct {
        logic [15:0] id;
        logic [15:0] hops;
        logic [15:0] q;
        logic        fnd;
        int          lat;
        int          max_idx;
        int          start;
    } exp_t;

    exp_t exp_q[$];
    int   cyc     = 0;
    int   checks  = 0;
    int   errors  = 0;
    int   max_idx = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (nrst && busy && int'(rd_index) > max_idx) max_idx = int'(rd_index);
        if (done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done actual=1 expected=0 (t=%0t)", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("bestID",   int'(bestID),   int'(e.id));
                chk("bestHops", int'(bestHops), int'(e.hops));
                chk("bestQ",    int'(bestQ),    int'(e.q));
                chk("found",    int'(found),    int'(e.fnd));
                chk("latency",  cyc - e.start,  e.lat);
                chk("max_rd_index", max_idx,    e.max_idx);
            end
            max_idx = 0;
        end
    end

    task automatic clear_table();
        for (int i = 0; i < 16; i++) begin
            tab_id[i] = 16'h0; tab_hops[i] = 16'h0; tab_q[i] = 16'h0;
        end
    endtask

    task automatic set_entry(input int i, input logic [15:0] id, input logic [15:0] q,
                             input logic [15:0] h);
        tab_id[i] = id; tab_q[i] = q; tab_hops[i] = h;
    endtask

    task automatic load_table_a();
        clear_table();
        set_entry(0, 16'd1,  16'h3000, 16'd2);
        set_entry(1, 16'd17, 16'hB800, 16'd2);
        set_entry(2, 16'd5,  16'h1800, 16'd3);
    endtask

    // Inputs are scrambled after the pulse so unlatched use would show up.
    task automatic start_scan(input logic [15:0] n, input logic [15:0] x, input exp_t e);
        @(negedge clk);
        neighborCount = n;
        excludeID     = x;
        e.start       = cyc + 1;
        exp_q.push_back(e);
        en = 1'b1;
        @(negedge clk);
        en            = 1'b0;
        neighborCount = 16'd1;
        excludeID     = 16'd17;
    endtask

    task automatic wait_empty(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout actual=%0d expected=0 pending", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(posedge clk);
    endtask

    function automatic exp_t mk(input logic [15:0] id, input logic [15:0] h,
                                input logic [15:0] q, input logic f,
                                input int lat, input int mi);
        exp_t e;
        e.id = id; e.hops = h; e.q = q; e.fnd = f; e.lat = lat; e.max_idx = mi; e.start = 0;
        return e;
    endfunction

    initial begin
        nrst = 1'b0; en = 1'b0; neighborCount = '0; excludeID = '0;
        clear_table();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rd_index", int'(rd_index), 0);
        chk("rst_bestID",   int'(bestID),   0);
        chk("rst_found",    int'(found),    0);
        chk("rst_busy",     int'(busy),     0);
        chk("rst_done",     int'(done),     0);
        @(negedge clk);
        nrst = 1'b1;

        start_scan(16'd0, 16'd0, mk(16'd0, 16'd0, 16'h0, 1'b0, 1, 0));
        wait_empty("cnt0");

        load_table_a();
        start_scan(16'd3, 16'd0, mk(16'd17, 16'd2, 16'hB800, 1'b1, 7, 2));
        wait_empty("table_a");

        clear_table();
        set_entry(0, 16'd1, 16'h4000, 16'd6);
        set_entry(1, 16'd9, 16'h4000, 16'd7);
        start_scan(16'd2, 16'd0, mk(16'd1, 16'd6, 16'h4000, 1'b1, 5, 1));
        wait_empty("tie");

        load_table_a();
        start_scan(16'd3, 16'd17, mk(16'd1, 16'd2, 16'h3000, 1'b1, 7, 2));
        wait_empty("exclude17");

        clear_table();
        set_entry(0, 16'd1, 16'h5000, 16'd1);
        start_scan(16'd1, 16'd1, mk(16'd0, 16'd0, 16'h0, 1'b0, 3, 0));
        wait_empty("exclude_only");

        clear_table();
        set_entry(0, 16'd0, 16'hFFFF, 16'd1);
        start_scan(16'd1, 16'd0, mk(16'd0, 16'd0, 16'h0, 1'b0, 3, 0));
        wait_empty("zero_id");

        // Max Q 0xF000 appears at index 12 and 14; lower index must win.
        for (int i = 0; i < 16; i++)
            set_entry(i, 16'(i + 1), 16'(16'h1000 + i * 16'h100), 16'(i + 2));
        tab_q[12] = 16'hF000;
        tab_q[14] = 16'hF000;
        start_scan(16'd40, 16'd0, mk(16'd13, 16'd14, 16'hF000, 1'b1, 33, 15));
        repeat (10) @(posedge clk);
        @(negedge clk);
        en = 1'b1; neighborCount = 16'd2;
        @(negedge clk);
        en = 1'b0;
        wait_empty("clamp40");
        repeat (40) @(posedge clk);

        // Abort a scan after its third edge with an asynchronous reset.
        load_table_a();
        @(negedge clk);
        neighborCount = 16'd3; excludeID = 16'd0; en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        nrst = 1'b0;
        #1;
        chk("abort_rd_index", int'(rd_index), 0);
        chk("abort_bestID",   int'(bestID),   0);
        chk("abort_bestHops", int'(bestHops), 0);
        chk("abort_bestQ",    int'(bestQ),    0);
        chk("abort_found",    int'(found),    0);
        chk("abort_busy",     int'(busy),     0);
        chk("abort_done",     int'(done),     0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        max_idx = 0;
        nrst = 1'b1;
        start_scan(16'd3, 16'd0, mk(16'd17, 16'd2, 16'hB800, 1'b1, 7, 2));
        wait_empty("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/qtable_best_hop_select.md
Name: qtable_best_hop_select

Overview:
- Reader-side companion to the Q-table update block. The update block writes neighbour entries (ID, hops, Q-value) into the per-field memory banks. This block reads those banks back.
- On request, it scans entries 0..neighborCount-1 and returns the neighbour with the highest Q-value as the next hop for the packet forwarder.
- It sits between the neighbour memory banks and the routing/transmit controller of the EER-RL node.

Parameters:
- WORD_WIDTH, 16, width of IDs, hop counts, Q-values and counts.
- MAX_NEIGHBORS, 16, table depth; the scan count is clamped to this value.
- IDX_WIDTH, 4, width of the read index (log2 of MAX_NEIGHBORS).

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- en  in  1  one-cycle start pulse; sampled only in IDLE.
- neighborCount  in  WORD_WIDTH  number of valid table entries.
- excludeID  in  WORD_WIDTH  neighbour ID that must not be chosen (previous hop); 0 means no exclusion.
- rd_index  out  IDX_WIDTH  read address driven to all neighbour banks.
- mSourceID  in  WORD_WIDTH  ID bank data_out.
- mSourceHops  in  WORD_WIDTH  hops bank data_out.
- mQValue  in  WORD_WIDTH  Q-value bank data_out, unsigned fixed point.
- bestID  out  WORD_WIDTH  selected neighbour ID.
- bestHops  out  WORD_WIDTH  selected neighbour hop count.
- bestQ  out  WORD_WIDTH  selected neighbour Q-value.
- found  out  1  at least one eligible entry existed.
- busy  out  1  high from the cycle after en until done.
- done  out  1  one-cycle pulse when the result is valid.

Behaviour:
- Reset (async, nrst=0): state=IDLE. rd_index, bestID, bestHops, bestQ, found, busy and done are all 0.
- Memory model: banks register the address. m* inputs present the entry at the rd_index value of the previous cycle.
- FSM has four states: IDLE, ADDR, CMP, FIN.
- IDLE, en=1:
  - Latch cnt = min(neighborCount, MAX_NEIGHBORS) and excludeID.
  - Clear bestQ, bestID, bestHops and found. Set rd_index=0 and busy=1.
  - If cnt=0, go to FIN; otherwise go to ADDR.
- ADDR: one wait cycle while the memory captures rd_index; go to CMP.
- CMP: entry k (k = rd_index) is eligible if mSourceID != 0 and (latched excludeID = 0 or mSourceID != latched excludeID).
  - Take entry k if it is eligible and either found=0 or mQValue > bestQ (unsigned, strict).
  - Taking an entry loads bestID/bestHops/bestQ from m* and sets found=1.
  - Ties keep the lowest index.
  - If k = cnt-1, go to FIN; otherwise rd_index <= k+1 and go to ADDR.
- FIN: done=1 for exactly one cycle, busy=0, then IDLE.
- Latency: done is asserted 2*cnt+1 cycles after the en sampling edge; for cnt=0 it is 1 cycle.
- Outputs hold their values after done until the next accepted en.
- en while busy is ignored, with no restart or queueing.
- Changes to neighborCount or excludeID during a scan have no effect; both are latched.
- found=0 at done implies bestID=bestHops=bestQ=0. The forwarder must then fall back to CH/sink broadcast.
- rd_index never exceeds cnt-1 and never wraps.
- nrst low mid-scan aborts immediately into the reset values; no done is issued.

Test Plan:
- neighborCount=0, en pulse -> done exactly 1 cycle later; found=0; bestID=0; rd_index stays 0.
- Table {ID1 Q=0x3000 H2, ID17 Q=0xB800 H2, ID5 Q=0x1800 H3}, cnt=3, excludeID=0 -> rd_index steps 0,1,2; done 7 cycles after en; bestID=17, bestQ=0xB800, bestHops=2, found=1.
- Tie: ID1 and ID9 both Q=0x4000 -> bestID=1. Then excludeID=17 on the 3-entry table -> bestID=1, bestQ=0x3000.
- Single entry ID1 with excludeID=1, and separately an entry with ID=0 -> found=0, all best outputs 0, done still pulses.
- neighborCount=40 with MAX_NEIGHBORS=16 -> scan stops at rd_index=15; done 33 cycles after en. An en pulse mid-scan is ignored, with no second done.
- Assert nrst low at cycle 3 of a scan -> all outputs 0 asynchronously. A subsequent en after release runs a full clean scan with the correct result.
